// File: rtl/stepper_move_ctrl.sv
// Move-command stage in front of the stepper phase sequencer: accepts one move at a time and
// paces step_tick along a trapezoidal/triangular period profile with a controlled-stop abort.
module stepper_move_ctrl #(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 20,
    parameter int PER_START = 50000,
    parameter int ACCEL_DEC = 500,
    parameter int MIN_PER   = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step_tick,
    output logic             motor_dir,
    output logic             motor_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_e;

    localparam logic [PER_W:0]   START_X  = (PER_W+1)'(PER_START);
    localparam logic [PER_W:0]   DEC_X    = (PER_W+1)'(ACCEL_DEC);
    localparam logic [PER_W:0]   MIN_X    = (PER_W+1)'(MIN_PER);
    localparam logic [PER_W:0]   ZERO_X   = {(PER_W+1){1'b0}};
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [CNT_W-1:0]   ramp_q, ramp_d;
    logic [PER_W-1:0]   tgt_q, tgt_d;
    logic [PER_W-1:0]   cur_q, cur_d;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               en_q, en_d;
    logic               done_q, done_d;

    logic [PER_W:0]     cmd_tgt_x;
    logic [PER_W:0]     cmd_cur_x;
    logic [PER_W:0]     tgt_x;
    logic [PER_W:0]     faster_x;
    logic [PER_W:0]     slower_x;
    logic [PER_W:0]     abort_new_x;
    logic [PER_W:0]     abort_sum_x;
    logic [CNT_W-1:0]   left_m1;
    logic [CNT_W-1:0]   ramp_n;
    logic [CNT_W-1:0]   left_clamp;

    // Shorter period by one ramp increment, never below the cruise target and never underflowing.
    function automatic logic [PER_W:0] period_faster(input logic [PER_W:0] p_x,
                                                      input logic [PER_W:0] t_x);
        logic [PER_W:0] dn_x;
        dn_x = (p_x > DEC_X) ? (p_x - DEC_X) : ZERO_X;
        return (dn_x > t_x) ? dn_x : t_x;
    endfunction

    // Longer period by one ramp increment, capped at the start/stop period.
    function automatic logic [PER_W:0] period_slower(input logic [PER_W:0] p_x);
        logic [PER_W:0] up_x;
        up_x = p_x + DEC_X;
        return (up_x < START_X) ? up_x : START_X;
    endfunction

    // Next-state and next-output computation for the whole move sequencer.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        left_d      = left_q;
        ramp_d      = ramp_q;
        tgt_d       = tgt_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        en_d        = en_q;
        done_d      = 1'b0;
        abort_new_x = ZERO_X;
        abort_sum_x = ZERO_X;
        left_clamp  = left_q;

        cmd_tgt_x = ({1'b0, cmd_period} > MIN_X) ? {1'b0, cmd_period} : MIN_X;
        cmd_cur_x = (cmd_tgt_x > START_X) ? cmd_tgt_x : START_X;
        tgt_x     = {1'b0, tgt_q};
        faster_x  = period_faster({1'b0, cur_q}, tgt_x);
        slower_x  = period_slower({1'b0, cur_q});
        left_m1   = left_q - CNT_ONE;
        ramp_n    = ((state_q == ST_ACCEL) && (ramp_q != CNT_MAX)) ? (ramp_q + CNT_ONE) : ramp_q;

        case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (cmd_valid) begin
                    dir_d  = cmd_dir;
                    left_d = cmd_steps;
                    ramp_d = CNT_ZERO;
                    tgt_d  = PER_W'(cmd_tgt_x);
                    cur_d  = PER_W'(cmd_cur_x);
                    // Acceptance cycle counts as cycle 0 of the first interval.
                    cnt_d  = PER_W'(cmd_cur_x) - PER_ONE;
                    if (cmd_steps == CNT_ZERO) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cmd_tgt_x >= START_X) begin
                        en_d    = 1'b1;
                        state_d = ST_CRUISE;
                    end else begin
                        en_d    = 1'b1;
                        state_d = ST_ACCEL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (left_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - PER_ONE;
                    if (cnt_q <= PER_ONE) begin
                        tick_d = 1'b1;
                        left_d = left_m1;
                        ramp_d = ramp_n;
                        if (left_m1 == CNT_ZERO) begin
                            cur_d = cur_q;
                        end else if ((state_q != ST_DECEL) && (left_m1 <= ramp_n)) begin
                            state_d = ST_DECEL;
                            cur_d   = PER_W'(slower_x);
                        end else if (state_q == ST_ACCEL) begin
                            cur_d   = PER_W'(faster_x);
                            state_d = (faster_x == tgt_x) ? ST_CRUISE : ST_ACCEL;
                        end else if (state_q == ST_DECEL) begin
                            cur_d = PER_W'(slower_x);
                        end else begin
                            cur_d = cur_q;
                        end
                        cnt_d = cur_d;
                    end else begin
                        tick_d = 1'b0;
                    end

                    // Abort acts on the post-tick view: only ramp steps remain to be issued.
                    if (abort && (state_q != ST_DECEL) && (left_d != CNT_ZERO)) begin
                        left_clamp = (left_d < ramp_d) ? left_d : ramp_d;
                        if (left_clamp == CNT_ZERO) begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                            left_d  = CNT_ZERO;
                        end else if (state_d != ST_DECEL) begin
                            left_d      = left_clamp;
                            // Stretch the step in flight to the first decel period.
                            abort_new_x = period_slower({1'b0, cur_d});
                            abort_sum_x = {1'b0, cnt_d} + abort_new_x;
                            cnt_d       = (abort_sum_x > {1'b0, cur_d}) ?
                                          PER_W'(abort_sum_x - {1'b0, cur_d}) : PER_ONE;
                            cur_d       = PER_W'(abort_new_x);
                            state_d     = ST_DECEL;
                        end else begin
                            left_d = left_clamp;
                        end
                    end else begin
                        left_clamp = left_d;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            left_q  <= CNT_ZERO;
            ramp_q  <= CNT_ZERO;
            tgt_q   <= {PER_W{1'b0}};
            cur_q   <= {PER_W{1'b0}};
            cnt_q   <= {PER_W{1'b0}};
            tick_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            left_q  <= left_d;
            ramp_q  <= ramp_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign step_tick  = tick_q;
    assign motor_dir  = dir_q;
    assign motor_en   = en_q;
    assign done       = done_q;
    assign steps_left = left_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl with small profile constants so the
// ramp timings can be worked out by hand.
module tb_stepper_move_ctrl;

    localparam int CNT_W = 16;
    localparam int PER_W = 20;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;
    logic             abort;
    logic             step_tick;
    logic             motor_dir;
    logic             motor_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    stepper_move_ctrl #(
        .CNT_W(CNT_W), .PER_W(PER_W), .PER_START(10), .ACCEL_DEC(2), .MIN_PER(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .step_tick(step_tick), .motor_dir(motor_dir), .motor_en(motor_en), .busy(busy),
        .done(done), .steps_left(steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int done_cyc;
    int en_first;
    int en_last;
    int ready_bad;
    int ticks[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ticks(input string tag, input int exp[]);
        chk({tag, "_count"}, ticks.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < ticks.size()) chk($sformatf("%s_tick%0d", tag, i), ticks[i], exp[i]);
            else                  chk($sformatf("%s_tick%0d", tag, i), -1, exp[i]);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (step_tick) ticks.push_back(cyc);
            if (done && done_cyc < 0) done_cyc = cyc;
            if (motor_en) begin
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
        end
    endtask

    task automatic restart_tracking();
        cyc      = 0;
        done_cyc = -1;
        en_first = -1;
        en_last  = -1;
        ticks.delete();
    endtask

    // Presents a command in cycle 0 and leaves the bench in cycle 1 with cmd_valid low.
    task automatic start_cmd(input logic dir, input int steps, input int period);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = CNT_W'(steps);
        cmd_period = PER_W'(period);
        restart_tracking();
        run_cycles(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        restart_tracking();
        repeat (3) @(negedge clk);
        chk("rst_tick", step_tick, 0);
        chk("rst_en", motor_en, 0);
        chk("rst_dir", motor_dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_left", steps_left, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero-step command completes immediately
        start_cmd(1'b0, 0, 10);
        run_cycles(5);
        chk("t1_done_cyc", done_cyc, 1);
        chk("t1_no_tick", ticks.size(), 0);
        chk("t1_no_en", en_first, -1);

        // 2: cruise-only move
        start_cmd(1'b1, 3, 10);
        chk("t2_dir", motor_dir, 1);
        chk("t2_busy", busy, 1);
        chk("t2_ready", cmd_ready, 0);
        chk("t2_left", steps_left, 3);
        run_cycles(35);
        chk_ticks("t2", '{10, 20, 30});
        chk("t2_en_first", en_first, 1);
        chk("t2_en_last", en_last, 30);
        chk("t2_done_cyc", done_cyc, 31);
        chk("t2_left_end", steps_left, 0);

        // 3: full trapezoid
        start_cmd(1'b0, 8, 4);
        run_cycles(60);
        chk_ticks("t3", '{10, 18, 24, 28, 32, 38, 46, 56});
        chk("t3_done_cyc", done_cyc, 57);
        chk("t3_en_last", en_last, 56);
        chk("t3_dir", motor_dir, 0);

        // 4: abort during cruise with ramp=3
        start_cmd(1'b0, 100, 4);
        run_cycles(39);
        chk("t4_left_at_abort", steps_left, 93);
        abort = 1'b1;
        run_cycles(1);
        abort = 1'b0;
        chk("t4_left_clamped", steps_left, 3);
        run_cycles(40);
        chk_ticks("t4", '{10, 18, 24, 28, 32, 36, 40, 46, 54, 64});
        chk("t4_done_cyc", done_cyc, 65);
        chk("t4_left_end", steps_left, 0);

        // 5: second command held while busy, accepted in the done cycle
        start_cmd(1'b0, 3, 10);
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = CNT_W'(1);
        cmd_period = PER_W'(10);
        ready_bad  = 0;
        while (!done && cyc < 40) begin
            if (cmd_ready) ready_bad++;
            run_cycles(1);
        end
        chk("t5_ready_held_low", ready_bad, 0);
        chk("t5_done_cyc", done_cyc, 31);
        chk("t5_ready_at_done", cmd_ready, 1);
        restart_tracking();
        run_cycles(1);
        cmd_valid = 1'b0;
        chk("t5_second_dir", motor_dir, 1);
        chk("t5_second_busy", busy, 1);
        run_cycles(15);
        chk_ticks("t5b", '{10});
        chk("t5b_done_cyc", done_cyc, 11);

        // 6: reset mid-move
        start_cmd(1'b0, 8, 4);
        run_cycles(14);
        rst_n = 1'b0;
        #1;
        chk("t6_en", motor_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_left", steps_left, 0);
        chk("t6_tick", step_tick, 0);
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(30);
        chk_ticks("t6", '{10});
        chk("t6_en_last", en_last, 15);
        chk("t6_no_done", done_cyc, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
